// File: rtl/uart_cmd_bridge.sv
// ---------------------------------------------------------------------------
// uart_cmd_bridge
//
// Turns a UART byte stream into single or burst word transactions on a
// req/gnt/rvalid host bus, then sends read data and a status byte back on the
// transmit stream.
//
// Command byte : bit7 = write, bits[6:4] must be zero, bits[3:0] = words - 1.
// Then AddrWidth/8 address bytes (little-endian), then for writes
// DataWidth/8 bytes per word (little-endian). Reads return DataWidth/8 bytes
// per word, and every command ends with one status byte:
// 0x00 ok, 0x01 bus error, 0x02 bad command, 0x03 parser timeout.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i  receive byte stream, rx_ready_o accepts it
//   tx_valid_o/tx_data_o  transmit byte stream, tx_ready_i accepts it
//   req_o/gnt_i           bus request and grant
//   addr_o/we_o/wdata_o   word-aligned address, write enable, write data
//   be_o                  byte enables (always all ones)
//   rvalid_i/rdata_i      bus response and read data
//   err_i                 bus error, qualified by rvalid_i
//   busy_o                high whenever a command is in progress
//
// Optional feature: define UART_CMD_BRIDGE_TIMEOUT_EN to build an idle timer
// that aborts a half-received command after TimeoutCycles quiet cycles.
// ---------------------------------------------------------------------------
module uart_cmd_bridge #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned MaxBurst      = 16,
    parameter int unsigned TimeoutCycles = 65536
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    output logic                   rx_ready_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   we_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i,
    input  logic                   err_i,
    output logic                   busy_o
);

    localparam int unsigned DataBytes = DataWidth / 8;
    localparam int unsigned AddrBytes = AddrWidth / 8;
    localparam int unsigned MaxBytes  = (DataBytes > AddrBytes) ? DataBytes : AddrBytes;
    localparam int unsigned ByteCntW  = $clog2(MaxBytes + 1);
    localparam int unsigned WordCntW  = 5;

    localparam logic [7:0] StOk      = 8'h00;
    localparam logic [7:0] StBusErr  = 8'h01;
    localparam logic [7:0] StBadCmd  = 8'h02;
    localparam logic [7:0] StTimeout = 8'h03;

    // The low address bits below one word are dropped on the bus side only;
    // the raw register keeps counting so the increment stays a plain add.
    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(DataBytes - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS_REQ,
        BUS_WAIT,
        RD_DATA,
        STATUS
    } state_e;

    state_e                state_q,     state_d;
    logic                  isWrite_q,   isWrite_d;
    logic [WordCntW-1:0]   wordsLeft_q, wordsLeft_d;
    logic [ByteCntW-1:0]   byteIdx_q,   byteIdx_d;
    logic [AddrWidth-1:0]  addr_q,      addr_d;
    logic [DataWidth-1:0]  wdata_q,     wdata_d;
    logic [DataWidth-1:0]  rdata_q,     rdata_d;
    logic [7:0]            status_q,    status_d;

    logic                  rxReady;
    logic                  txValid;
    logic [7:0]            txData;
    logic                  reqOut;

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
    localparam int unsigned ToCntW = $clog2(TimeoutCycles + 1);
    logic [ToCntW-1:0]     toCnt_q, toCnt_d;
    logic                  rxFire;
`else
    // TimeoutCycles only matters when the idle timer is built.
    logic                  unusedTimeout;
    assign unusedTimeout = (TimeoutCycles != 0);
`endif

    // State and datapath registers. Reset drops any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            isWrite_q   <= 1'b0;
            wordsLeft_q <= '0;
            byteIdx_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            status_q    <= StOk;
        end else begin
            state_q     <= state_d;
            isWrite_q   <= isWrite_d;
            wordsLeft_q <= wordsLeft_d;
            byteIdx_q   <= byteIdx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
        end
    end

    // Next-state and output logic. wordsLeft_q counts words whose bus
    // response has not yet come back; byteIdx_q walks the bytes of the
    // address or data word currently being received or sent.
    always_comb begin
        state_d     = state_q;
        isWrite_d   = isWrite_q;
        wordsLeft_d = wordsLeft_q;
        byteIdx_d   = byteIdx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        rxReady     = 1'b0;
        txValid     = 1'b0;
        txData      = 8'h00;
        reqOut      = 1'b0;

        unique case (state_q)
            IDLE: begin
                rxReady = 1'b1;
                if (rx_valid_i) begin
                    isWrite_d   = rx_data_i[7];
                    wordsLeft_d = {1'b0, rx_data_i[3:0]} + WordCntW'(1);
                    byteIdx_d   = '0;
                    status_d    = StOk;
                    if ((rx_data_i[6:4] == 3'b000) &&
                        ({1'b0, rx_data_i[3:0]} < WordCntW'(MaxBurst))) begin
                        state_d = ADDR;
                    end else begin
                        // Rejected commands answer at once and never read
                        // address bytes; the next byte is a fresh command.
                        status_d = StBadCmd;
                        state_d  = STATUS;
                    end
                end
            end

            ADDR: begin
                rxReady = 1'b1;
                if (rx_valid_i) begin
                    addr_d[8*int'(byteIdx_q) +: 8] = rx_data_i;
                    if (byteIdx_q == ByteCntW'(AddrBytes - 1)) begin
                        byteIdx_d = '0;
                        state_d   = isWrite_q ? WDATA : BUS_REQ;
                    end else begin
                        byteIdx_d = byteIdx_q + ByteCntW'(1);
                    end
                end
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
                else if (toCnt_q == ToCntW'(TimeoutCycles)) begin
                    status_d = StTimeout;
                    state_d  = STATUS;
                end
`endif
            end

            WDATA: begin
                rxReady = 1'b1;
                if (rx_valid_i) begin
                    wdata_d[8*int'(byteIdx_q) +: 8] = rx_data_i;
                    if (byteIdx_q == ByteCntW'(DataBytes - 1)) begin
                        byteIdx_d = '0;
                        state_d   = BUS_REQ;
                    end else begin
                        byteIdx_d = byteIdx_q + ByteCntW'(1);
                    end
                end
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
                else if (toCnt_q == ToCntW'(TimeoutCycles)) begin
                    status_d = StTimeout;
                    state_d  = STATUS;
                end
`endif
            end

            BUS_REQ: begin
                reqOut = 1'b1;
                if (gnt_i) begin
                    state_d = BUS_WAIT;
                end
            end

            BUS_WAIT: begin
                if (rvalid_i) begin
                    if (err_i) begin
                        status_d = StBusErr;
                        state_d  = STATUS;
                    end else begin
                        addr_d      = addr_q + AddrWidth'(DataBytes);
                        wordsLeft_d = wordsLeft_q - WordCntW'(1);
                        byteIdx_d   = '0;
                        if (!isWrite_q) begin
                            rdata_d = rdata_i;
                            state_d = RD_DATA;
                        end else if (wordsLeft_q == WordCntW'(1)) begin
                            state_d = STATUS;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end

            RD_DATA: begin
                txValid = 1'b1;
                txData  = rdata_q[8*int'(byteIdx_q) +: 8];
                if (tx_ready_i) begin
                    if (byteIdx_q == ByteCntW'(DataBytes - 1)) begin
                        byteIdx_d = '0;
                        state_d   = (wordsLeft_q != '0) ? BUS_REQ : STATUS;
                    end else begin
                        byteIdx_d = byteIdx_q + ByteCntW'(1);
                    end
                end
            end

            STATUS: begin
                txValid = 1'b1;
                txData  = status_q;
                if (tx_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
    assign rxFire = rx_valid_i && rxReady;

    // Idle timer for the byte parser: counts quiet cycles in ADDR/WDATA and
    // restarts on every accepted byte and whenever the state changes.
    always_comb begin
        toCnt_d = '0;
        if (((state_q == ADDR) || (state_q == WDATA)) &&
            (state_d == state_q) && !rxFire) begin
            toCnt_d = toCnt_q + ToCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`endif

    assign rx_ready_o = rxReady;
    assign tx_valid_o = txValid;
    assign tx_data_o  = txData;
    assign req_o      = reqOut;
    assign addr_o     = addr_q & ~OffsetMask;
    assign we_o       = isWrite_q;
    assign wdata_o    = wdata_q;
    assign be_o       = '1;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_bridge
//
// Directed bench for uart_cmd_bridge (32-bit data/address). A command-level
// model turns each command into the list of bus transactions and tx bytes it
// must produce; a monitor compares every bus handshake and tx byte against
// that list and checks that stalled outputs hold still.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_bridge;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    typedef logic [7:0] bytes_t[$];

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        req_o;
    logic        gnt_i;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;
    logic        busy_o;

    // Second instance with a smaller burst limit, driven only for the
    // bad-command case.
    logic        rx4Valid;
    logic [7:0]  rx4Data;
    logic        rx4Ready;
    logic        tx4Valid;
    logic [7:0]  tx4Data;
    logic        req4;
    logic [31:0] addr4;
    logic        we4;
    logic [31:0] wdata4;
    logic [3:0]  be4;
    logic        busy4;

    int errors = 0;
    int checks = 0;

    txn_t        expTxn[$];
    logic [7:0]  expTx[$];
    logic [7:0]  gotTx[$];
    logic [31:0] gotAddr[$];
    logic [31:0] gotWdata[$];
    int          reqCycles = 0;
    int          grantCount = 0;
    int          busBase = 0;
    logic        req4Seen = 1'b0;

    logic [31:0] wrData[16];
    logic [31:0] rdData[16];
    int          errWord = 99;
    int          gntDelay = 0;
    int          txStall = 0;

    always #5 clk_i = ~clk_i;

    uart_cmd_bridge #(
        .DataWidth(32), .AddrWidth(32), .MaxBurst(16), .TimeoutCycles(100)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o),
        .wdata_o(wdata_o), .be_o(be_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .err_i(err_i), .busy_o(busy_o)
    );

    uart_cmd_bridge #(
        .DataWidth(32), .AddrWidth(32), .MaxBurst(4), .TimeoutCycles(100)
    ) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_valid_i(rx4Valid), .rx_data_i(rx4Data), .rx_ready_o(rx4Ready),
        .tx_valid_o(tx4Valid), .tx_data_o(tx4Data), .tx_ready_i(1'b1),
        .req_o(req4), .gnt_i(1'b0), .addr_o(addr4), .we_o(we4),
        .wdata_o(wdata4), .be_o(be4), .rvalid_i(1'b0), .rdata_i(32'h0),
        .err_i(1'b0), .busy_o(busy4)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name, input logic [127:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected no such event", name, actual);
    endtask

    // Command-level model: what a command must do on the bus and on tx.
    task automatic modelCommand(input logic [7:0] cmd, input logic [31:0] addr,
                                input int maxBurst);
        int          n;
        logic [31:0] base;
        txn_t        t;
        n = int'(cmd[3:0]) + 1;
        if (cmd[6:4] != 3'b000 || n > maxBurst) begin
            expTx.push_back(8'h02);
            return;
        end
        base = {addr[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            t.addr  = base + 32'(4 * i);
            t.we    = cmd[7];
            t.wdata = cmd[7] ? wrData[i] : 32'h0;
            expTxn.push_back(t);
            if (i == errWord) begin
                expTx.push_back(8'h01);
                return;
            end
            if (!cmd[7]) begin
                for (int b = 0; b < 4; b++) expTx.push_back(rdData[i][8*b +: 8]);
            end
        end
        expTx.push_back(8'h00);
    endtask

    task automatic applyStimulus(input bytes_t bytes);
        int cnt;
        @(posedge clk_i);
        #1;
        foreach (bytes[i]) begin
            cnt = 0;
            rx_valid_i = 1'b1;
            rx_data_i  = bytes[i];
            @(negedge clk_i);
            while (!rx_ready_o && cnt < 2000) begin
                cnt++;
                @(negedge clk_i);
            end
            if (!rx_ready_o) begin
                failEvent("rx accept timeout", 128'(i));
                rx_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic waitDone(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk_i);
        while ((expTx.size() != 0 || expTxn.size() != 0 || busy_o) && cnt < 3000) begin
            cnt++;
            @(negedge clk_i);
        end
        checkOutput({name, " drained"},
                    128'(expTx.size() + expTxn.size() + int'(busy_o)), 128'(0));
    endtask

    // Bus responder: grants after gntDelay request cycles, answers one
    // cycle after the grant with rdData of that word, err on errWord.
    initial begin
        int waitCnt;
        int respIdx;
        logic respPending;
        waitCnt = 0; respIdx = 0; respPending = 1'b0;
        gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
            if (!rst_ni) begin
                respPending = 1'b0;
                waitCnt = 0;
            end else if (respPending) begin
                rvalid_i = 1'b1;
                rdata_i  = rdData[respIdx & 15];
                err_i    = (respIdx == errWord);
                respPending = 1'b0;
            end else if (req_o) begin
                if (waitCnt >= gntDelay) begin
                    gnt_i = 1'b1;
                    waitCnt = 0;
                    respPending = 1'b1;
                    respIdx = grantCount - busBase;
                    grantCount++;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Transmit sink: holds tx_ready_i low txStall cycles per byte.
    initial begin
        int stallCnt;
        stallCnt = 0;
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (tx_valid_o && rst_ni) begin
                if (stallCnt >= txStall) begin
                    tx_ready_i = 1'b1;
                    stallCnt = 0;
                end else begin
                    tx_ready_i = 1'b0;
                    stallCnt++;
                end
            end else begin
                tx_ready_i = 1'b0;
                stallCnt = 0;
            end
        end
    end

    // Compare process: every bus handshake and tx byte against the model,
    // plus hold-still checks while req_o or tx_valid_o is stalled.
    logic        prevReqWait = 1'b0;
    logic [64:0] prevReq = '0;
    logic        prevTxWait = 1'b0;
    logic [7:0]  prevTxData = '0;

    always @(negedge clk_i) begin
        txn_t t;
        if (req4) req4Seen = 1'b1;
        if (rst_ni) begin
            if (req_o) reqCycles++;
            if (req_o && gnt_i) begin
                gotAddr.push_back(addr_o);
                gotWdata.push_back(wdata_o);
                if (expTxn.size() == 0) begin
                    failEvent("unexpected bus request", 128'(addr_o));
                end else begin
                    t = expTxn.pop_front();
                    checkOutput("bus addr", 128'(addr_o), 128'(t.addr));
                    checkOutput("bus we", 128'(we_o), 128'(t.we));
                    if (t.we) checkOutput("bus wdata", 128'(wdata_o), 128'(t.wdata));
                    checkOutput("bus be", 128'(be_o), 128'(4'hF));
                end
            end
            if (prevReqWait) begin
                checkOutput("req held until grant", 128'({req_o, addr_o, we_o, wdata_o}),
                            128'({1'b1, prevReq}));
            end
            prevReqWait = req_o && !gnt_i;
            prevReq     = {addr_o, we_o, wdata_o};

            if (tx_valid_o && tx_ready_i) begin
                gotTx.push_back(tx_data_o);
                if (expTx.size() == 0) begin
                    failEvent("unexpected tx byte", 128'(tx_data_o));
                end else begin
                    checkOutput("tx byte", 128'(tx_data_o), 128'(expTx.pop_front()));
                end
            end
            if (prevTxWait) begin
                checkOutput("tx held while stalled", 128'({tx_valid_o, tx_data_o}),
                            128'({1'b1, prevTxData}));
            end
            prevTxWait = tx_valid_o && !tx_ready_i;
            prevTxData = tx_data_o;
        end else begin
            prevReqWait = 1'b0;
            prevTxWait  = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int txBase;
        int addrBase;
        int reqBase;
        int cnt;
        logic seen;

        rst_ni = 1'b0;
        rx_valid_i = 1'b0; rx_data_i = 8'h00;
        rx4Valid = 1'b0; rx4Data = 8'h00;
        foreach (wrData[i]) begin wrData[i] = 32'h0; rdData[i] = 32'h0; end

        repeat (3) @(negedge clk_i);
        checkOutput("reset outputs",
                    128'({req_o, tx_valid_o, busy_o, we_o, tx_data_o, addr_o, wdata_o}),
                    128'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("idle after reset", 128'({rx_ready_o, busy_o, tx_valid_o, req_o}),
                    128'(4'b1000));

        // Single write to 0x1000.
        $display("[TB] single write");
        busBase = grantCount; errWord = 99;
        txBase = gotTx.size(); addrBase = gotAddr.size();
        wrData[0] = 32'hDEADBEEF;
        modelCommand(8'h80, 32'h0000_1000, 16);
        checkOutput("model write addr", 128'(expTxn[0].addr), 128'(32'h0000_1000));
        applyStimulus('{8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        waitDone("single write");
        checkOutput("write addr literal", 128'(gotAddr[addrBase]), 128'(32'h0000_1000));
        checkOutput("write data literal", 128'(gotWdata[addrBase]), 128'(32'hDEADBEEF));
        checkOutput("write tx count", 128'(gotTx.size() - txBase), 128'(1));
        checkOutput("write status literal", 128'(gotTx[txBase]), 128'(8'h00));

        // Four-word burst read from 0x2004.
        $display("[TB] burst read");
        busBase = grantCount; errWord = 99;
        txBase = gotTx.size(); addrBase = gotAddr.size();
        rdData[0] = 32'h11111111; rdData[1] = 32'h22222222;
        rdData[2] = 32'h33333333; rdData[3] = 32'h44444444;
        modelCommand(8'h03, 32'h0000_2004, 16);
        checkOutput("model read byte count", 128'(expTx.size()), 128'(17));
        applyStimulus('{8'h03, 8'h04, 8'h20, 8'h00, 8'h00});
        waitDone("burst read");
        checkOutput("read last addr literal", 128'(gotAddr[addrBase+3]), 128'(32'h0000_2010));
        checkOutput("read tx count", 128'(gotTx.size() - txBase), 128'(17));
        checkOutput("read byte4 literal", 128'(gotTx[txBase+4]), 128'(8'h22));
        checkOutput("read status literal", 128'(gotTx[txBase+16]), 128'(8'h00));

        // Bus error on the second word of a four-word read.
        $display("[TB] bus error mid-burst");
        busBase = grantCount; errWord = 1;
        txBase = gotTx.size(); addrBase = gotAddr.size();
        modelCommand(8'h03, 32'h0000_3000, 16);
        applyStimulus('{8'h03, 8'h00, 8'h30, 8'h00, 8'h00});
        waitDone("bus error");
        repeat (5) @(negedge clk_i);
        checkOutput("error grant count", 128'(gotAddr.size() - addrBase), 128'(2));
        checkOutput("error tx count", 128'(gotTx.size() - txBase), 128'(5));
        checkOutput("error status literal", 128'(gotTx[txBase+4]), 128'(8'h01));
        errWord = 99;

        // Reserved bits set, then a normal write right behind it.
        $display("[TB] bad command");
        busBase = grantCount;
        txBase = gotTx.size(); addrBase = gotAddr.size();
        wrData[0] = 32'h01234567;
        modelCommand(8'h40, 32'h0, 16);
        modelCommand(8'h80, 32'h0000_4000, 16);
        applyStimulus('{8'h40, 8'h80, 8'h00, 8'h40, 8'h00, 8'h00,
                        8'h67, 8'h45, 8'h23, 8'h01});
        waitDone("bad command");
        checkOutput("bad cmd status literal", 128'(gotTx[txBase]), 128'(8'h02));
        checkOutput("bad cmd then write addr", 128'(gotAddr[addrBase]), 128'(32'h0000_4000));

        // Unaligned two-word write wrapping past the top of the address space.
        $display("[TB] address wrap");
        busBase = grantCount;
        addrBase = gotAddr.size();
        wrData[0] = 32'hA5A5A5A5; wrData[1] = 32'h5A5A5A5A;
        modelCommand(8'h81, 32'hFFFF_FFFE, 16);
        applyStimulus('{8'h81, 8'hFE, 8'hFF, 8'hFF, 8'hFF,
                        8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A});
        waitDone("address wrap");
        checkOutput("wrap first addr literal", 128'(gotAddr[addrBase]), 128'(32'hFFFF_FFFC));
        checkOutput("wrap second addr literal", 128'(gotAddr[addrBase+1]), 128'(32'h0));

        // Slow grant and slow transmit sink.
        $display("[TB] backpressure");
        gntDelay = 5; txStall = 3;
        busBase = grantCount;
        txBase = gotTx.size(); reqBase = reqCycles;
        rdData[0] = 32'hA1B2C3D4; rdData[1] = 32'h0F1E2D3C;
        modelCommand(8'h01, 32'h0000_5008, 16);
        applyStimulus('{8'h01, 8'h08, 8'h50, 8'h00, 8'h00});
        waitDone("backpressure read");
        checkOutput("stalled read req cycles", 128'(reqCycles - reqBase), 128'(12));
        checkOutput("stalled read byte0 literal", 128'(gotTx[txBase]), 128'(8'hD4));
        checkOutput("stalled read tx count", 128'(gotTx.size() - txBase), 128'(9));
        busBase = grantCount; reqBase = reqCycles;
        wrData[0] = 32'hCAFEF00D;
        modelCommand(8'h80, 32'h0000_6000, 16);
        applyStimulus('{8'h80, 8'h00, 8'h60, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
        waitDone("backpressure write");
        checkOutput("stalled write req cycles", 128'(reqCycles - reqBase), 128'(6));
        gntDelay = 0; txStall = 0;

        // Smaller burst limit: 8 words requested against a limit of 4.
        $display("[TB] burst limit");
        @(posedge clk_i); #1;
        rx4Valid = 1'b1; rx4Data = 8'h07;
        @(negedge clk_i);
        checkOutput("mb4 ready in idle", 128'(rx4Ready), 128'(1));
        @(posedge clk_i); #1;
        rx4Valid = 1'b0;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge clk_i);
            if (tx4Valid) begin
                seen = 1'b1;
                checkOutput("mb4 bad status", 128'(tx4Data), 128'(8'h02));
            end
            cnt++;
        end
        checkOutput("mb4 status seen", 128'(seen), 128'(1));
        repeat (2) @(negedge clk_i);
        checkOutput("mb4 idle again", 128'({busy4, tx4Valid}), 128'(2'b00));
        @(posedge clk_i); #1;
        rx4Valid = 1'b1; rx4Data = 8'h03;
        @(posedge clk_i); #1;
        rx4Valid = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("mb4 four words accepted", 128'({busy4, tx4Valid, rx4Ready}),
                    128'(3'b101));
        checkOutput("mb4 no request", 128'(req4Seen), 128'(0));

        // Parser stalls after two address bytes.
        $display("[TB] parser idle");
        txBase = gotTx.size();
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
        expTx.push_back(8'h03);
`endif
        applyStimulus('{8'h80, 8'h00, 8'h10});
        repeat (130) @(negedge clk_i);
`ifdef UART_CMD_BRIDGE_TIMEOUT_EN
        checkOutput("timeout status count", 128'(gotTx.size() - txBase), 128'(1));
        checkOutput("timeout status literal", 128'(gotTx[txBase]), 128'(8'h03));
        checkOutput("idle after timeout", 128'(busy_o), 128'(0));
`else
        checkOutput("no timeout tx", 128'(gotTx.size() - txBase), 128'(0));
        checkOutput("still busy without timeout", 128'(busy_o), 128'(1));
`endif

        // Reset in the middle of a command drops it silently.
        $display("[TB] reset mid-command");
        applyStimulus('{8'h81, 8'h00});
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("outputs in mid-op reset",
                    128'({req_o, tx_valid_o, busy_o, we_o, tx_data_o, addr_o, wdata_o}),
                    128'(0));
        rst_ni = 1'b1;
        txBase = gotTx.size();
        repeat (20) @(negedge clk_i);
        checkOutput("no response after reset", 128'(gotTx.size() - txBase), 128'(0));
        checkOutput("idle after mid-op reset", 128'({busy_o, rx_ready_o}), 128'(2'b01));

        checkOutput("model queues empty", 128'(expTx.size() + expTxn.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
